// File: rtl/pack8_sequencer_wn.sv
// Packs eight inwidth-bit input words into one 8-lane output word, lane 0 first.
// A flush request forces out a partially filled word with the unused upper lanes zeroed.
module pack8_sequencer_wn #(
  parameter int unsigned inwidth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [inwidth-1:0]     in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   flush_done,
  output logic [8*inwidth-1:0]   out_data,
  output logic [3:0]             out_lanes,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned OutWidth = 8 * inwidth;

  logic [2:0]          cnt_q, cnt_d;
  logic [inwidth-1:0]  lanes_q [7];
  logic [OutWidth-1:0] out_data_q, out_data_d;
  logic [3:0]          out_lanes_q, out_lanes_d;
  logic                out_valid_q, out_valid_d;
  logic                flush_done_q, flush_done_d;

  logic                slot_free;
  logic                last;
  logic                acc;
  logic                full_emit;
  logic                flush_emit;
  logic                emit;
  logic [3:0]          fill;
  logic [OutWidth-1:0] merged;

  assign slot_free  = !out_valid_q || out_ready;
  assign last       = (cnt_q == 3'd7);
  // Only the last slot needs the output register; earlier lanes always have room.
  assign in_ready   = !last || slot_free;
  assign acc        = in_valid && in_ready;
  assign full_emit  = acc && last;
  assign flush_emit = flush && slot_free && ((cnt_q != 3'd0) || acc) && !full_emit;
  assign emit       = full_emit || flush_emit;
  assign fill       = {1'b0, cnt_q} + {3'b000, acc};

  // Buffered lanes plus the word arriving this cycle; lanes at or above fill read as zero.
  always_comb begin
    merged = '0;
    for (int k = 0; k < 7; k++) begin
      if (k < int'(fill)) begin
        if (acc && (k == int'(cnt_q))) begin
          merged[k*inwidth +: inwidth] = in_data;
        end else begin
          merged[k*inwidth +: inwidth] = lanes_q[k];
        end
      end
    end
    if (fill == 4'd8) begin
      merged[7*inwidth +: inwidth] = in_data;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      out_data_d  = merged;
      out_lanes_d = fill;
      out_valid_d = 1'b1;
      cnt_d       = 3'd0;
    end else if (acc) begin
      cnt_d = cnt_q + 3'd1;
    end
    // A flush with nothing buffered and nothing arriving completes without a word.
    flush_done_d = flush && (emit || ((cnt_q == 3'd0) && !acc));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 3'd0;
      out_data_q   <= '0;
      out_lanes_q  <= 4'd0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        lanes_q[k] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_lanes_q  <= out_lanes_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
      for (int k = 0; k < 7; k++) begin
        if (acc && !last && (cnt_q == 3'(k))) begin
          lanes_q[k] <= in_data;
        end
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_lanes  = out_lanes_q;
  assign out_valid  = out_valid_q;
  assign flush_done = flush_done_q;

endmodule
